// File: rtl/cond_eval_unit_pkg.sv
// Shared constants for the condition-evaluation unit: ARM condition codes and
// the bit positions of N, Z, C and V inside the 4-bit status word.
package cond_eval_unit_pkg;

    // ARM condition-field encodings
    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    // Bit positions inside the NZCV word
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // AL never depends on the flags, so it is never held back by pending writers.
    function automatic logic cond_is_always(input logic [3:0] cond);
        return cond == COND_AL;
    endfunction

endpackage

// File: rtl/cond_eval_unit_decode.sv
// Pure combinational decoder: one ARM condition field against one NZCV word.
module cond_decode
    import cond_eval_unit_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    // Map the condition field onto its flag expression
    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = ~w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = ~w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = ~w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = ~w_v;
            COND_HI: o_pass = w_c & ~w_z;
            COND_LS: o_pass = ~w_c | w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = ~w_z & (w_n == w_v);
            COND_LE: o_pass = w_z | (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_eval_unit.sv
// Multi-lane condition evaluator with an architectural NZCV register, a
// same-cycle flag bypass from EXE, and a counter of in-flight flag writers
// that holds ID back while flags are still unresolved.
module cond_eval_unit
    import cond_eval_unit_pkg::*;
#(
    parameter int unsigned LANES   = 2,
    parameter int unsigned PEND_W  = 3,
    parameter int unsigned REG_OUT = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_status_we,
    input  logic [3:0]         i_status_in,
    input  logic               i_flag_issue,
    input  logic [LANES-1:0]   i_lane_valid,
    input  logic [4*LANES-1:0] i_lane_cond,
    output logic [LANES-1:0]   o_lane_result,
    output logic [LANES-1:0]   o_lane_rvalid,
    output logic               o_stall,
    output logic [3:0]         o_status_q,
    output logic               o_pend_err
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [3:0]        r_status;
    logic [PEND_W-1:0] r_pend;
    logic              r_pend_err;

    logic [3:0]        w_flags_eff;
    logic              w_pend_inc;
    logic              w_pend_dec;
    logic              w_pend_busy;
    logic [PEND_W-1:0] w_pend_after_bypass;
    logic [LANES-1:0]  w_lane_pass;
    logic [LANES-1:0]  w_lane_blocked;
    logic [LANES-1:0]  w_lane_rvalid;
    logic [LANES-1:0]  w_lane_result;

    // Architectural NZCV register, written by EXE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_status <= 4'b0000;
        end else if (i_status_we) begin
            r_status <= i_status_in;
        end
    end

    // Flags written this cycle are forwarded straight to the decoders
    assign w_flags_eff = i_status_we ? i_status_in : r_status;

    // An issue and a retire in the same cycle cancel out
    assign w_pend_inc = i_flag_issue & ~i_status_we;
    assign w_pend_dec = i_status_we & ~i_flag_issue;

    // Pending-writer counter: saturates at both ends and flags the misuse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend     <= '0;
            r_pend_err <= 1'b0;
        end else if (w_pend_inc) begin
            if (r_pend == PEND_MAX) begin
                r_pend_err <= 1'b1;
            end else begin
                r_pend <= r_pend + PEND_ONE;
            end
        end else if (w_pend_dec) begin
            if (r_pend == '0) begin
                r_pend_err <= 1'b1;
            end else begin
                r_pend <= r_pend - PEND_ONE;
            end
        end
    end

    // The writer retiring this cycle is already covered by the bypass. The
    // issue input is deliberately ignored here: a writer entering the pipe
    // now is younger than the instruction being evaluated.
    assign w_pend_after_bypass = (i_status_we && (r_pend != '0)) ? (r_pend - PEND_ONE) : r_pend;
    assign w_pend_busy         = (w_pend_after_bypass != '0);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        cond_decode u_cond_decode (
            .i_cond  (i_lane_cond[4*gi +: 4]),
            .i_flags (w_flags_eff),
            .o_pass  (w_lane_pass[gi])
        );

        assign w_lane_blocked[gi] = i_lane_valid[gi] & w_pend_busy &
                                    ~cond_is_always(i_lane_cond[4*gi +: 4]);
    end

    // Blocked lanes report nothing; the others are independent of them
    assign w_lane_rvalid = i_lane_valid & ~w_lane_blocked;
    assign w_lane_result = w_lane_rvalid & w_lane_pass;
    assign o_stall       = |w_lane_blocked;

    if (REG_OUT != 0) begin : g_reg_out
        logic [LANES-1:0] r_lane_result;
        logic [LANES-1:0] r_lane_rvalid;

        // One-cycle-latency result registers
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_lane_result <= '0;
                r_lane_rvalid <= '0;
            end else begin
                r_lane_result <= w_lane_result;
                r_lane_rvalid <= w_lane_rvalid;
            end
        end

        assign o_lane_result = r_lane_result;
        assign o_lane_rvalid = r_lane_rvalid;
    end else begin : g_comb_out
        assign o_lane_result = w_lane_result;
        assign o_lane_rvalid = w_lane_rvalid;
    end

    assign o_status_q = r_status;
    assign o_pend_err = r_pend_err;

endmodule

// File: tb/tb_cond_eval_unit.sv
// Directed bench for cond_eval_unit (LANES=2, PEND_W=3, REG_OUT=1).
module tb_cond_eval_unit;

    logic       clk;
    logic       rst_n;
    logic       status_we;
    logic [3:0] status_in;
    logic       flag_issue;
    logic [1:0] lane_valid;
    logic [7:0] lane_cond;
    logic [1:0] lane_result;
    logic [1:0] lane_rvalid;
    logic       stall;
    logic [3:0] status_q;
    logic       pend_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] status;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    vec_t vecs[32];

    cond_eval_unit #(
        .LANES   (2),
        .PEND_W  (3),
        .REG_OUT (1)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_status_we   (status_we),
        .i_status_in   (status_in),
        .i_flag_issue  (flag_issue),
        .i_lane_valid  (lane_valid),
        .i_lane_cond   (lane_cond),
        .o_lane_result (lane_result),
        .o_lane_rvalid (lane_rvalid),
        .o_stall       (stall),
        .o_status_q    (status_q),
        .o_pend_err    (pend_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [0:15] exp_a;
        logic [0:15] exp_b;

        // Expected pass bits for cond 0..15, worked out by hand from the NZCV words
        exp_a = 16'b0110_1001_1001_0110;   // status 1010
        exp_b = 16'b1001_0110_0101_0110;   // status 0101
        for (int i = 0; i < 16; i++) begin
            vecs[i]      = '{status: 4'b1010, cond: 4'(i), exp: exp_a[i]};
            vecs[i + 16] = '{status: 4'b0101, cond: 4'(i), exp: exp_b[i]};
        end

        rst_n      = 1'b0;
        status_we  = 1'b0;
        status_in  = 4'b0000;
        flag_issue = 1'b0;
        lane_valid = 2'b00;
        lane_cond  = 8'h00;

        // Reset state
        #3;
        check("reset_status_q", 8'(status_q), 8'h0);
        check("reset_pend_err", 8'(pend_err), 8'h0);
        check("reset_rvalid", 8'(lane_rvalid), 8'h0);
        check("reset_result", 8'(lane_result), 8'h0);
        check("reset_stall", 8'(stall), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Condition sweeps; status loaded with issue+we together so pend stays 0
        for (int i = 0; i < 32; i++) begin
            if (i % 16 == 0) begin
                @(negedge clk);
                lane_valid = 2'b00;
                status_we  = 1'b1;
                flag_issue = 1'b1;
                status_in  = vecs[i].status;
                @(negedge clk);
                status_we  = 1'b0;
                flag_issue = 1'b0;
                check("status_load", 8'(status_q), 8'(vecs[i].status));
            end else begin
                @(negedge clk);
            end
            lane_valid = 2'b01;
            lane_cond  = {4'd0, vecs[i].cond};
            @(posedge clk);
            #1;
            check($sformatf("sweep_s%b_c%0d", vecs[i].status, vecs[i].cond),
                  8'(lane_result[0]), 8'(vecs[i].exp));
            check("sweep_rvalid", 8'(lane_rvalid), 8'h1);
        end
        @(negedge clk);
        lane_valid = 2'b00;
        #1;
        check("both_we_issue_no_err", 8'(pend_err), 8'h0);
        check("both_we_issue_no_stall", 8'(stall), 8'h0);

        // Pending writer blocks EQ, then same-cycle bypass releases it
        @(negedge clk);
        flag_issue = 1'b1;
        @(negedge clk);
        flag_issue = 1'b0;
        lane_valid = 2'b01;
        lane_cond  = {4'd0, 4'd0};
        #1;
        check("pend_stall", 8'(stall), 8'h1);
        @(posedge clk);
        #1;
        check("pend_rvalid", 8'(lane_rvalid), 8'h0);
        check("pend_result", 8'(lane_result), 8'h0);
        @(negedge clk);
        status_we = 1'b1;
        status_in = 4'b0100;
        #1;
        check("bypass_stall", 8'(stall), 8'h0);
        @(posedge clk);
        #1;
        check("bypass_rvalid", 8'(lane_rvalid), 8'h1);
        check("bypass_result", 8'(lane_result), 8'h1);
        check("bypass_status_q", 8'(status_q), 8'h4);
        @(negedge clk);
        status_we  = 1'b0;
        lane_valid = 2'b00;

        // Lane independence: AL passes while NE is blocked
        @(negedge clk);
        flag_issue = 1'b1;
        @(negedge clk);
        flag_issue = 1'b0;
        lane_valid = 2'b11;
        lane_cond  = {4'd1, 4'd14};
        #1;
        check("indep_stall", 8'(stall), 8'h1);
        @(posedge clk);
        #1;
        check("indep_rvalid", 8'(lane_rvalid), 8'h1);
        check("indep_result", 8'(lane_result), 8'h1);
        @(negedge clk);
        lane_valid = 2'b00;
        status_we  = 1'b1;
        @(negedge clk);
        status_we = 1'b0;

        // Issue in the same cycle as a request does not block it
        lane_valid = 2'b01;
        lane_cond  = {4'd0, 4'd0};
        flag_issue = 1'b1;
        #1;
        check("issue_same_cycle_stall", 8'(stall), 8'h0);
        @(posedge clk);
        #1;
        check("issue_same_cycle_rvalid", 8'(lane_rvalid), 8'h1);
        check("issue_same_cycle_result", 8'(lane_result), 8'h1);
        @(negedge clk);
        flag_issue = 1'b0;
        lane_valid = 2'b00;
        status_we  = 1'b1;
        @(negedge clk);
        status_we = 1'b0;
        #1;
        check("no_err_before_sat", 8'(pend_err), 8'h0);

        // Eight issues saturate the 3-bit counter at 7
        @(negedge clk);
        flag_issue = 1'b1;
        repeat (8) @(negedge clk);
        flag_issue = 1'b0;
        #1;
        check("sat_pend_err", 8'(pend_err), 8'h1);
        @(negedge clk);
        status_in = 4'b1111;
        status_we = 1'b1;
        repeat (6) @(negedge clk);
        status_we  = 1'b0;
        lane_valid = 2'b01;
        #1;
        check("sat_pend_one_stall", 8'(stall), 8'h1);
        @(negedge clk);
        lane_valid = 2'b00;
        status_we  = 1'b1;
        @(negedge clk);
        status_we  = 1'b0;
        lane_valid = 2'b01;
        #1;
        check("sat_pend_zero_stall", 8'(stall), 8'h0);
        @(negedge clk);
        lane_valid = 2'b00;
        status_we  = 1'b1;
        @(negedge clk);
        status_we  = 1'b0;
        lane_valid = 2'b01;
        #1;
        check("underflow_hold_stall", 8'(stall), 8'h0);
        check("underflow_pend_err", 8'(pend_err), 8'h1);
        check("underflow_status_q", 8'(status_q), 8'hf);

        // Asynchronous reset in the middle of a stall
        @(negedge clk);
        lane_valid = 2'b00;
        flag_issue = 1'b1;
        @(negedge clk);
        flag_issue = 1'b0;
        lane_valid = 2'b11;
        lane_cond  = {4'd14, 4'd0};
        #1;
        check("pre_reset_stall", 8'(stall), 8'h1);
        @(posedge clk);
        #1;
        check("pre_reset_rvalid", 8'(lane_rvalid), 8'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_stall", 8'(stall), 8'h0);
        check("async_status_q", 8'(status_q), 8'h0);
        check("async_pend_err", 8'(pend_err), 8'h0);
        check("async_rvalid", 8'(lane_rvalid), 8'h0);
        check("async_result", 8'(lane_result), 8'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        lane_valid = 2'b00;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cond_eval_unit.md
COND_EVAL_UNIT -- requirements
Module: cond_eval_unit

Interface
REQ-001 Parameter LANES, default 2, meaning the number of independent condition-evaluation lanes (1..4).
REQ-002 Parameter PEND_W, default 3, meaning the width of the pending-flag-writer counter.
REQ-003 Parameter REG_OUT, default 1, meaning 1 gives registered results and 0 gives combinational results.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 status_we  input  1  the EXE stage writes flags this cycle.
REQ-007 status_in  input  4  new flags, bit order [3]=N [2]=Z [1]=C [0]=V.
REQ-008 flag_issue  input  1  a flag-setting (S-bit) instruction entered the pipe.
REQ-009 lane_valid  input  LANES  per-lane evaluation request.
REQ-010 lane_cond  input  4*LANES  per-lane ARM condition field, lane i at [4i+3:4i].
REQ-011 lane_result  output  LANES  per-lane condition-passed result.
REQ-012 lane_rvalid  output  LANES  per-lane result valid.
REQ-013 stall  output  1  the ID stage must hold because flags are unresolved.
REQ-014 status_q  output  4  architectural NZCV register.
REQ-015 pend_err  output  1  sticky flag for a pending-counter overflow or underflow.

Function
REQ-016 status_q SHALL load status_in on every edge where status_we=1 and SHALL otherwise hold.
REQ-017 Effective flags SHALL be status_in when status_we=1 (same-cycle bypass), else status_q.
REQ-018 Decode SHALL be: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
REQ-019 pend counter: +1 on flag_issue only; -1 on status_we only; unchanged when both or neither are asserted.
REQ-020 The increment at the all-ones value SHALL saturate and set pend_err.
REQ-021 The decrement at zero SHALL hold zero and set pend_err.
REQ-022 A lane SHALL be blocked when lane_valid=1, its cond is not 14 (AL), and pend_after_bypass is nonzero, where pend_after_bypass = pend minus status_we.
REQ-023 stall SHALL be the combinational OR of all lane-blocked terms.
REQ-024 Each unblocked valid lane SHALL produce lane_rvalid=1 with lane_result decoded from the effective flags.
REQ-025 A blocked lane SHALL produce lane_rvalid=0 and lane_result=0.
REQ-026 With REG_OUT=1, lane_result and lane_rvalid SHALL appear one cycle after the request (latency 1).
REQ-027 With REG_OUT=0, lane_result and lane_rvalid SHALL be valid in the same cycle (latency 0).
REQ-028 Lanes SHALL be independent: one lane's block SHALL NOT suppress another lane's result, but stall SHALL still assert.
REQ-029 flag_issue=1 in the same cycle as a lane request SHALL NOT block that lane, because the counter is sampled before the increment.

Reset
REQ-030 While rst_n=0, status_q, pend, pend_err, and registered lane_result/lane_rvalid SHALL be 0 immediately, without waiting for a clock edge.
REQ-031 The first rising edge after rst_n returns high SHALL perform normal updates.
REQ-032 Reset asserted mid-stall SHALL clear stall in the same cycle, since pend becomes 0.

Structure
REQ-033 A shared package SHALL hold the condition-code constants (EQ..NV) and the NZCV bit-index constants.
REQ-034 One sub-module, cond_decode, SHALL be the pure 4-bit cond by 4-bit flags to 1-bit decoder, instantiated LANES times.

Verification
REQ-035 Status loaded with 1010, lane0 cond swept 0..15 -> results 0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,0.
REQ-036 Status loaded with 0101, sweep 0..15 -> results 1,0,0,1,0,1,1,0,0,1,0,1,0,1,1,0.
REQ-037 flag_issue pulse, then lane0 EQ request -> stall=1 and rvalid0=0; when status_we=1 with status_in=0100 in that cycle -> stall=0 and result=1 via bypass.
REQ-038 pend=1, lane0 AL and lane1 NE requested -> stall=1, rvalid=01, result0=1.
REQ-039 Eight flag_issue pulses with PEND_W=3 -> pend holds 7 and pend_err=1; status_we at pend=0 -> pend stays 0 and pend_err stays 1.
REQ-040 rst_n dropped mid-stall -> stall, status_q, and pend_err go to 0 asynchronously.
